// File: rtl/la_trigger_matcher.sv
`default_nettype none
// ============================================================================
// Module   : la_trigger_matcher
// Purpose  : Logic-analyzer trigger: masked value match, optional toggle
//            qualification and run-length count; emits a one-cycle trigger.
// Options  : LA_TRIGGER_EDGE_EN enables the per-bit toggle (edge) qualifier.
// Revision : 1.0  initial release
// ============================================================================
module la_trigger_matcher #(
   parameter int DATA_WIDTH = 32,
   parameter int COUNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic                  disarm,
   input  logic [DATA_WIDTH-1:0] cfg_mask,
   input  logic [DATA_WIDTH-1:0] cfg_value,
   input  logic [DATA_WIDTH-1:0] cfg_edge_mask,
   input  logic [COUNT_BITS-1:0] cfg_count,
   input  logic                  din_valid,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  trigger,
   output logic                  armed,
   output logic                  triggered,
   output logic [COUNT_BITS-1:0] run_len
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_COUNTING = 2'd2,
      S_FIRED    = 2'd3
   } state_t;

   localparam logic [COUNT_BITS-1:0] c_count_max = '1;
   localparam logic [COUNT_BITS-1:0] c_count_one = COUNT_BITS'(1);

   state_t                r_state;
   state_t                w_state_next;
   logic [DATA_WIDTH-1:0] r_mask_l;
   logic [DATA_WIDTH-1:0] r_value_l;
   logic [COUNT_BITS-1:0] r_count_l;
   logic [COUNT_BITS-1:0] r_run_len;
   logic [COUNT_BITS-1:0] w_run_len_next;
   logic                  r_trigger;
   logic                  w_trigger_next;
   logic                  r_triggered;
   logic                  w_triggered_next;

   logic                  w_active;
   logic                  w_match;
   logic                  w_edge;
   logic                  w_hit;
   logic                  w_fire;
   logic [COUNT_BITS:0]   w_run_inc;
   logic [COUNT_BITS-1:0] w_run_sat;
   logic [COUNT_BITS-1:0] w_target;

   assign w_active = (r_state == S_ARMED) || (r_state == S_COUNTING);

   // Configuration snapshot; disarm wins over a simultaneous arm.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask_l  <= '0;
         r_value_l <= '0;
         r_count_l <= '0;
      end else if (arm && !disarm) begin
         r_mask_l  <= cfg_mask;
         r_value_l <= cfg_value;
         r_count_l <= cfg_count;
      end
   end

`ifdef LA_TRIGGER_EDGE_EN
   logic [DATA_WIDTH-1:0] r_edge_l;
   logic [DATA_WIDTH-1:0] r_prev;
   logic                  r_prev_vld;

   // Without a previous word only an empty edge mask can qualify.
   assign w_edge = r_prev_vld ? (((din ^ r_prev) & r_edge_l) == r_edge_l)
                              : (r_edge_l == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edge_l   <= '0;
         r_prev     <= '0;
         r_prev_vld <= 1'b0;
      end else if (!disarm) begin
         if (arm) begin
            r_edge_l   <= cfg_edge_mask;
            r_prev_vld <= 1'b0;
         end else if (w_active && din_valid) begin
            r_prev     <= din;
            r_prev_vld <= 1'b1;
         end
      end
   end
`else
   logic w_unused_edge;
   assign w_unused_edge = ^cfg_edge_mask;
   assign w_edge        = 1'b1;
`endif

   assign w_match   = ((din ^ r_value_l) & r_mask_l) == '0;
   assign w_hit     = din_valid && w_match && w_edge;
   assign w_run_inc = {1'b0, r_run_len} + {{COUNT_BITS{1'b0}}, 1'b1};
   assign w_run_sat = w_run_inc[COUNT_BITS] ? c_count_max : w_run_inc[COUNT_BITS-1:0];
   assign w_target  = (r_count_l == '0) ? c_count_one : r_count_l;
   assign w_fire    = w_hit && (w_run_inc >= {1'b0, w_target});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_run_len   <= '0;
         r_trigger   <= 1'b0;
         r_triggered <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_run_len   <= w_run_len_next;
         r_trigger   <= w_trigger_next;
         r_triggered <= w_triggered_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_run_len_next   = r_run_len;
      w_trigger_next   = 1'b0;
      w_triggered_next = r_triggered;
      if (disarm) begin
         w_state_next   = S_IDLE;
         w_run_len_next = '0;
      end else if (arm) begin
         w_state_next     = S_ARMED;
         w_run_len_next   = '0;
         w_triggered_next = 1'b0;
      end else begin
         case (r_state)
            S_ARMED, S_COUNTING: begin
               if (din_valid) begin
                  if (w_hit) begin
                     w_run_len_next = w_run_sat;
                     if (w_fire) begin
                        w_state_next     = S_FIRED;
                        w_trigger_next   = 1'b1;
                        w_triggered_next = 1'b1;
                     end else begin
                        w_state_next = S_COUNTING;
                     end
                  end else begin
                     w_run_len_next = '0;
                     w_state_next   = S_ARMED;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign trigger   = r_trigger;
   assign armed     = w_active;
   assign triggered = r_triggered;
   assign run_len   = r_run_len;

endmodule
`default_nettype wire

// File: doc/la_trigger_matcher.md
LA_TRIGGER_MATCHER -- requirements
Module: la_trigger_matcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each sample word.
REQ-002 SHALL have parameter COUNT_BITS, default 16, width of the run-length counter and cfg_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic runs in this domain.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port arm, input, 1, single-cycle pulse that latches the cfg_* inputs and starts matching.
REQ-006 SHALL have port disarm, input, 1, single-cycle pulse that aborts matching.
REQ-007 SHALL have port cfg_mask, input, DATA_WIDTH, bits that take part in the value compare.
REQ-008 SHALL have port cfg_value, input, DATA_WIDTH, required value of the masked bits.
REQ-009 SHALL have port cfg_edge_mask, input, DATA_WIDTH, bits that must toggle relative to the previous valid word.
REQ-010 SHALL have port cfg_count, input, COUNT_BITS, number of consecutive hit words required to fire.
REQ-011 SHALL have port din_valid, input, 1, din carries a sample this cycle.
REQ-012 SHALL have port din, input, DATA_WIDTH, sample word.
REQ-013 SHALL have port trigger, output, 1, single-cycle pulse that feeds the analyzer rx_trigger.
REQ-014 SHALL have port armed, output, 1, high in states ARMED and COUNTING.
REQ-015 SHALL have port triggered, output, 1, sticky flag: fired since the last arm.
REQ-016 SHALL have port run_len, output, COUNT_BITS, current consecutive-hit count.

Function
REQ-017 SHALL implement states IDLE, ARMED, COUNTING and FIRED.
REQ-018 SHALL copy all cfg_* inputs into internal registers on arm; later cfg_* changes SHALL have no effect until the next arm.
REQ-019 SHALL define match as ((din ^ value_l) & mask_l) == 0.
REQ-020 SHALL define edge as ((din ^ prev) & edge_l) == edge_l, where prev is the last valid din since arm; edge SHALL be false on the first valid word after arm unless edge_l == 0.
REQ-021 SHALL define hit as match && edge, evaluated only when din_valid is high.
REQ-022 SHALL, for each valid hit in ARMED/COUNTING, set run_len to run_len+1, saturating at all-ones, and enter COUNTING.
REQ-023 SHALL, for each valid non-hit in ARMED/COUNTING, clear run_len and return to ARMED.
REQ-024 SHALL leave run_len, prev and the state unchanged on cycles where din_valid is low.
REQ-025 SHALL enter FIRED and pulse trigger high for exactly one cycle, on the clock edge after the valid word whose hit brings run_len+1 >= count_l (latency 1).
REQ-026 SHALL treat count_l == 0 as 1.
REQ-027 SHALL set triggered in FIRED and hold it until the next arm.
REQ-028 SHALL keep trigger low in FIRED, ignoring data until re-armed.
REQ-029 SHALL, on arm in any state: clear run_len and triggered, invalidate prev, and enter ARMED.
REQ-030 SHALL, on disarm, enter IDLE and clear run_len; triggered is retained.
REQ-031 SHALL give disarm priority over arm when both are asserted in the same cycle.
REQ-032 SHALL ignore din in IDLE and FIRED.

Reset
REQ-033 SHALL, on rst_n low, immediately enter IDLE and drive trigger=0, armed=0, triggered=0, run_len=0, with prev invalid and the latched cfg registers zero.
REQ-034 SHALL, on reset during COUNTING, produce no trigger pulse after rst_n is released.

Configuration
REQ-035 SHALL gate edge qualification with macro LA_TRIGGER_EDGE_EN: when defined, REQ-020 applies; when undefined, edge is constant true, and cfg_edge_mask and the prev register are unused.

Verification
REQ-036 SHALL verify mask FFFF0000, value DEAD0000, count 1, din sequence 12345678, DEADBEEF -> trigger pulses one cycle after DEADBEEF, then triggered=1 and armed=0.
REQ-037 SHALL verify count 3 with hits H,H,miss,H,H,H and din_valid gaps inside the runs -> run_len goes 1,2,0,1,2,3, and trigger fires once after the 6th valid word.
REQ-038 SHALL verify with LA_TRIGGER_EDGE_EN defined, mask 0, edge_mask 00000001, din 0,0,1 -> no trigger on the first word, trigger after the third word.
REQ-039 SHALL verify arm and disarm in the same cycle -> state IDLE and armed=0; cfg changed mid-run -> no effect on matching.
REQ-040 SHALL verify rst_n asserted while run_len=2 of 3 -> all outputs 0 immediately, and a subsequent hit with no arm -> no trigger.
